mips_mem_unit: RTL and testbench
================================

# mips_mem_unit

Unified instruction/data memory for the multicycle MIPS core. It sits directly downstream of the CPU's fetch (state 1) and load/store (state 4) steps. The CPU's internal `Memory` array is replaced by a request/response port to this block. The block holds 1024 32-bit words, serves word reads, word writes and store-byte writes with a programmable fixed latency, and flags misaligned or out-of-range accesses.

## Interface

Parameters:
- `LATENCY`, default 2: cycles from the request-accept edge to the `resp_valid` cycle; legal range 1..15.
- `DEPTH_LOG2`, default 10: log2 of the word count; the memory holds 2^DEPTH_LOG2 words.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request this cycle.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_byte`  in  1: with `req_write`=1, selects a store-byte; ignored on reads.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: write data; a store-byte uses bits [7:0].
- `resp_valid`  out  1: one-cycle response pulse.
- `resp_rdata`  out  32: read data; held between responses.
- `resp_err`  out  1: access faulted; qualified by `resp_valid`.

## Operation

- States:
  - IDLE: `req_ready`=1.
  - WAIT: counting down.
  - RESP: `resp_valid`=1 for exactly one cycle, then back to IDLE.
- Transitions:
  - Accept when `req_valid && req_ready` at a rising edge.
  - On accept, the block registers write, byte, address and wdata.
  - Next state is WAIT with counter = LATENCY-1, or RESP directly when LATENCY=1.
  - WAIT decrements each cycle and moves to RESP when the counter is 0.
- Only one request is outstanding at a time. There is no response backpressure; the CPU always waits.
- Word index = `addr[DEPTH_LOG2+1:2]`.
- Errors (no memory change; `resp_rdata` is driven to 0 on the error response):
  - Out of range: `addr[31:DEPTH_LOG2+2]` ≠ 0.
  - Misaligned: `addr[1:0]` ≠ 0 on a word read or word write.
- Word read: `resp_rdata` is loaded with the addressed word on entry to RESP.
- Word write: the memory is updated at the same edge that enters RESP; `resp_rdata` is unchanged.
- Store-byte: big-endian lane select.
  - `addr[1:0]`=0 writes bits [31:24], 1 writes [23:16], 2 writes [15:8], 3 writes [7:0].
  - The other bytes of the word are preserved.
  - Any `addr[1:0]` is legal; there is no misalignment error.
- Errors are checked on the registered address at the RESP-entry edge.
- Memory contents are not cleared by reset. Testbenches preload the array hierarchically.

## Timing

- Reset values:
  - `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - State = IDLE, counter = 0.
- All outputs are registered; there is no combinational path from request inputs to outputs.
- Latency, for a request accepted at edge T:
  - `resp_valid` is high during the cycle following edge T+LATENCY-1.
  - This means it rises LATENCY edges after the accept edge, counting T as edge 1.
- `req_ready` drops at edge T and returns to 1 at the edge that ends the RESP cycle.
- Minimum spacing between accepts is LATENCY+1 edges.
- `req_*` inputs are ignored while `req_ready`=0. Holding `req_valid` high re-issues the request once `req_ready` returns.
- Read data is visible in the same cycle as `resp_valid`, so a read immediately after a write returns the new data.
- Reset asserted mid-transaction:
  - The pending request is discarded and any pending write is never committed.
  - All outputs return to their reset values asynchronously.
  - The first accept is possible at the first rising edge after reset deasserts.

## Test plan

- Word write, then read (LATENCY=2): SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
  - `resp_valid` pulses 2 edges after each accept.
  - Read returns 0xDEADBEEF, `resp_err`=0.
- Store-byte into that word: SB addr 0x11 data 0x000000AA, then LW 0x10.
  - Read returns 0xDEAABEEF.
  - Repeating with addr 0x13 and data 0x55 gives 0xDEAABE55.
- Misaligned and out-of-range accesses:
  - LW 0x12 gives `resp_err`=1 and `resp_rdata`=0.
  - SW 0x1000 data 0x1 gives `resp_err`=1.
  - A follow-up LW 0x0 returns the preloaded value, unchanged.
- Reset during WAIT of SW 0x20 data 0x12345678:
  - Outputs go to reset values immediately.
  - LW 0x20 after reset returns the original value.
- Back-to-back traffic with `req_valid` held high and LATENCY=1, then 3:
  - Accepts occur every 2 edges, then every 4 edges.
  - `resp_valid` is never high for 2 consecutive cycles.
- Fetch sequence: preload words 2..4 with instructions, then issue reads at 0x8, 0xC, 0x10.
  - Returned words match the preload in order.

Source files
------------

// File: rtl/mips_mem_unit_if.sv
// Request/response port between the multicycle MIPS core and its memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// are both high; req_* are ignored while req_ready is low. The response is a
// one-cycle resp_valid pulse with no backpressure; resp_rdata/resp_err are
// meaningful only while resp_valid is high (resp_rdata holds between pulses).
interface mips_mem_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mips_mem_unit.sv
// Unified instruction/data memory for the multicycle MIPS core.
// One outstanding request at a time, fixed programmable latency, word
// read/write plus big-endian store-byte, with misalignment and range faults.
module mips_mem_unit #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clock,
    input  logic              reset,
    mips_mem_unit_if.slave    bus,
    output logic [1:0]        dbg_state
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // Storage is deliberately not reset; contents survive a reset.
    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  op_write;
    logic                  op_byte;
    logic [31:0]           op_addr;
    logic [31:0]           op_wdata;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic                  op_oor;
    logic                  op_mis;
    logic                  op_err;
    logic [31:0]           cur_word;
    logic [31:0]           new_word;
    logic                  mem_we;

    // Operation seen at the RESP-entry edge: with LATENCY=1 that edge is the
    // accept edge itself, so the live request stands in for the registers.
    always_comb begin
        accept = bus.req_valid && req_ready_q;
        if (state_q == ST_IDLE) begin
            op_write = bus.req_write;
            op_byte  = bus.req_byte;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
        end else begin
            op_write = write_q;
            op_byte  = byte_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
        op_idx   = op_addr[DEPTH_LOG2+1:2];
        op_oor   = (op_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
        op_mis   = !(op_write && op_byte) && (op_addr[1:0] != 2'b00);
        op_err   = op_oor || op_mis;
        cur_word = mem[op_idx];
        new_word = cur_word;
        if (op_byte) begin
            case (op_addr[1:0])
                2'd0:    new_word[31:24] = op_wdata[7:0];
                2'd1:    new_word[23:16] = op_wdata[7:0];
                2'd2:    new_word[15:8]  = op_wdata[7:0];
                default: new_word[7:0]   = op_wdata[7:0];
            endcase
        end else begin
            new_word = op_wdata;
        end
    end

    // Next-state and registered-output logic for IDLE/WAIT/RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        byte_d       = byte_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        enter_resp   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d     = bus.req_write;
                    byte_d      = bus.req_byte;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: begin
                state_d      = ST_IDLE;
                cnt_d        = 4'd0;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase

        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = op_err;
            if (op_err) begin
                resp_rdata_d = 32'd0;
            end else if (!op_write) begin
                resp_rdata_d = cur_word;
            end
        end

        mem_we = enter_resp && op_write && !op_err && !reset;
    end

    // Control and output registers; reset discards any pending request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory commit happens on the edge that enters RESP.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[op_idx] <= new_word;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mips_mem_unit.sv
// Directed bench for mips_mem_unit: main instance at LATENCY=2, plus
// LATENCY=1 and LATENCY=3 instances for back-to-back spacing checks.
module tb_mips_mem_unit;

    logic clock;
    logic reset;
    logic [1:0] dbg2, dbg1, dbg3;

    int n_cmp;
    int n_bad;

    mips_mem_unit_if bus2();
    mips_mem_unit_if bus1();
    mips_mem_unit_if bus3();

    mips_mem_unit #(.LATENCY(2), .DEPTH_LOG2(10)) u_dut (
        .clock(clock), .reset(reset), .bus(bus2), .dbg_state(dbg2)
    );
    mips_mem_unit #(.LATENCY(1), .DEPTH_LOG2(10)) u_dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .dbg_state(dbg1)
    );
    mips_mem_unit #(.LATENCY(3), .DEPTH_LOG2(10)) u_dut3 (
        .clock(clock), .reset(reset), .bus(bus3), .dbg_state(dbg3)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One transaction on the LATENCY=2 instance; lat counts edges from the
    // accept edge (edge 1) to the edge after which resp_valid is seen high.
    task automatic op2(input logic w, input logic b, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic e, output int lat,
                       output logic v_after, output logic r_after);
        int n;
        @(negedge clock);
        n = 0;
        while (!bus2.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        bus2.req_valid = 1'b1;
        bus2.req_write = w;
        bus2.req_byte  = b;
        bus2.req_addr  = a;
        bus2.req_wdata = d;
        @(posedge clock);
        #1;
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.resp_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!bus2.resp_valid) lat = -1;
        rd = bus2.resp_rdata;
        e  = bus2.resp_err;
        @(posedge clock);
        #1;
        v_after = bus2.resp_valid;
        r_after = bus2.req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus2.req_ready); end
        n_cmp++; if (bus2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus2.resp_valid); end
        n_cmp++; if (bus2.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus2.resp_rdata); end
        n_cmp++; if (bus2.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus2.resp_err); end
        n_cmp++; if (dbg2 !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dbg2); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic e, va, ra; int lat;
        op2(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat, va, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_lat: got %0d want 2", lat); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b want 0", e); end
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL sw_rdata_held: got %h want 0", rd); end
        n_cmp++; if (va !== 1'b0) begin n_bad++; $display("FAIL sw_pulse: got %b want 0", va); end
        n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL sw_ready_back: got %b want 1", ra); end
        op2(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw_err: got %b want 0", e); end
        n_cmp++; if (va !== 1'b0) begin n_bad++; $display("FAIL lw_pulse: got %b want 0", va); end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd; logic e, va, ra; int lat;
        op2(1'b1, 1'b1, 32'h11, 32'h000000AA, rd, e, lat, va, ra);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sb1_err: got %b want 0", e); end
        op2(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'hDEAABEEF) begin n_bad++; $display("FAIL sb1_data: got %h want deaabeef", rd); end
        op2(1'b1, 1'b1, 32'h13, 32'h00000055, rd, e, lat, va, ra);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sb3_err: got %b want 0", e); end
        op2(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'hDEAABE55) begin n_bad++; $display("FAIL sb3_data: got %h want deaabe55", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e, va, ra; int lat;
        op2(1'b0, 1'b0, 32'h12, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL lw_mis_err: got %b want 1", e); end
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL lw_mis_rdata: got %h want 0", rd); end
        op2(1'b1, 1'b0, 32'h1000, 32'h1, rd, e, lat, va, ra);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sw_oor_err: got %b want 1", e); end
        op2(1'b0, 1'b0, 32'h0, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lw0_data: got %h want cafef00d", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw0_err: got %b want 0", e); end
        op2(1'b1, 1'b0, 32'h16, 32'hFFFFFFFF, rd, e, lat, va, ra);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sw_mis_err: got %b want 1", e); end
        op2(1'b0, 1'b0, 32'h14, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL lw14_data: got %h want 11112222", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e, va, ra; int lat;
        @(negedge clock);
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_byte  = 1'b0;
        bus2.req_addr  = 32'h20;
        bus2.req_wdata = 32'h12345678;
        @(posedge clock);
        #1;
        bus2.req_valid = 1'b0;
        n_cmp++; if (dbg2 !== 2'd1) begin n_bad++; $display("FAIL mid_in_wait: got %0d want 1", dbg2); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", bus2.req_ready); end
        n_cmp++; if (bus2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", bus2.resp_valid); end
        n_cmp++; if (bus2.resp_rdata !== 32'd0) begin n_bad++; $display("FAIL mid_rdata: got %h want 0", bus2.resp_rdata); end
        n_cmp++; if (bus2.resp_err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", bus2.resp_err); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        op2(1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL mid_lw_data: got %h want 0badf00d", rd); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mid_lw_lat: got %0d want 2", lat); end
    endtask

    // Hold req_valid high on the LATENCY=sel instance and watch spacing.
    task automatic run_b2b(input int sel, input logic [31:0] exp_word);
        int last_acc, n_acc;
        logic rdy_b, rv, rv_prev;
        logic [31:0] rd;
        @(negedge clock);
        if (sel == 1) begin
            bus1.req_write = 1'b0; bus1.req_byte = 1'b0;
            bus1.req_addr = 32'h4; bus1.req_valid = 1'b1;
        end else begin
            bus3.req_write = 1'b0; bus3.req_byte = 1'b0;
            bus3.req_addr = 32'h4; bus3.req_valid = 1'b1;
        end
        last_acc = 0; n_acc = 0; rv_prev = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            rdy_b = (sel == 1) ? bus1.req_ready : bus3.req_ready;
            @(posedge clock);
            #1;
            rv = (sel == 1) ? bus1.resp_valid : bus3.resp_valid;
            rd = (sel == 1) ? bus1.resp_rdata : bus3.resp_rdata;
            if (rdy_b) begin
                if (last_acc > 0) begin
                    n_cmp++; if (e - last_acc !== sel + 1) begin n_bad++; $display("FAIL b2b_spacing L%0d: got %0d want %0d", sel, e - last_acc, sel + 1); end
                end
                last_acc = e;
                n_acc++;
            end
            if (rv) begin
                n_cmp++; if (rv_prev !== 1'b0) begin n_bad++; $display("FAIL b2b_double_pulse L%0d: got 1 want 0 at edge %0d", sel, e); end
                n_cmp++; if (e - last_acc !== sel - 1) begin n_bad++; $display("FAIL b2b_latency L%0d: got %0d want %0d", sel, e - last_acc + 1, sel); end
                n_cmp++; if (rd !== exp_word) begin n_bad++; $display("FAIL b2b_data L%0d: got %h want %h", sel, rd, exp_word); end
            end
            rv_prev = rv;
            @(negedge clock);
        end
        if (sel == 1) bus1.req_valid = 1'b0;
        else          bus3.req_valid = 1'b0;
        n_cmp++; if (n_acc !== 17 / (sel + 1) + 1) begin n_bad++; $display("FAIL b2b_accepts L%0d: got %0d want %0d", sel, n_acc, 17 / (sel + 1) + 1); end
        repeat (6) @(posedge clock);
    endtask

    task automatic test_back_to_back();
        run_b2b(1, 32'h0A0B0C0D);
        run_b2b(3, 32'h01020304);
    endtask

    task automatic test_fetch();
        logic [31:0] rd; logic e, va, ra; int lat;
        u_dut.mem[2] = 32'h20080005;
        u_dut.mem[3] = 32'h01095020;
        u_dut.mem[4] = 32'hAC0A0000;
        op2(1'b0, 1'b0, 32'h8, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'h20080005) begin n_bad++; $display("FAIL fetch0: got %h want 20080005", rd); end
        op2(1'b0, 1'b0, 32'hC, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'h01095020) begin n_bad++; $display("FAIL fetch1: got %h want 01095020", rd); end
        op2(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, va, ra);
        n_cmp++; if (rd !== 32'hAC0A0000) begin n_bad++; $display("FAIL fetch2: got %h want ac0a0000", rd); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_byte = 1'b0;
        bus2.req_addr = 32'd0; bus2.req_wdata = 32'd0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_byte = 1'b0;
        bus1.req_addr = 32'd0; bus1.req_wdata = 32'd0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_byte = 1'b0;
        bus3.req_addr = 32'd0; bus3.req_wdata = 32'd0;
        #1;
        u_dut.mem[0]  = 32'hCAFEF00D;
        u_dut.mem[5]  = 32'h11112222;
        u_dut.mem[8]  = 32'h0BADF00D;
        u_dut1.mem[1] = 32'h0A0B0C0D;
        u_dut3.mem[1] = 32'h01020304;

        test_reset();
        test_word_rw();
        test_store_byte();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_fetch();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
